// File: rtl/io_config_loader_if.sv
// Handshake/bus bundle between the configuration source and io_config_loader.
// Signal names match the loader's legacy port list.
interface io_config_loader_if #(
  parameter int unsigned NUM_IO = 8
);
  logic                  CFG_START;
  logic                  CFG_DIN;
  logic                  CFG_VALID;
  logic [2*NUM_IO-1:0]   TSMUX_OUT;
  logic [NUM_IO-1:0]     DORREG_OUT;
  logic                  BUSY;
  logic                  CFG_DONE;
  logic                  CFG_ERR;

  modport master (
    output CFG_START, CFG_DIN, CFG_VALID,
    input  TSMUX_OUT, DORREG_OUT, BUSY, CFG_DONE, CFG_ERR
  );

  modport slave (
    input  CFG_START, CFG_DIN, CFG_VALID,
    output TSMUX_OUT, DORREG_OUT, BUSY, CFG_DONE, CFG_ERR
  );
endinterface

// File: rtl/io_config_loader.sv
// Serial frame loader: hunts for a sync word, shifts in 3 bits per IO block,
// checks even parity and commits TSMUX/DORREG to all IO blocks atomically.
module io_config_loader #(
  parameter int unsigned NUM_IO       = 8,
  parameter logic [7:0]  SYNC_WORD    = 8'hA5,
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic               IOCLK,
  input  logic               RST,
  io_config_loader_if.slave  cfg
);

  localparam int unsigned PW     = 3 * NUM_IO;
  localparam int unsigned CNT_W  = $clog2(PW + 1);
  localparam int unsigned HUNT_W = $clog2(SYNC_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(PW - 1);
  localparam logic [HUNT_W-1:0] HUNT_MAX = HUNT_W'(SYNC_TIMEOUT);

  logic [2:0]          state_q,  state_d;
  // Only the 7 newest bits are kept; the 8th comes straight from CFG_DIN.
  logic [6:0]          sync_q,   sync_d;
  logic [HUNT_W-1:0]   hunt_q,   hunt_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [PW-1:0]       shadow_q, shadow_d;
  logic                par_q,    par_d;
  logic [2*NUM_IO-1:0] tsmux_q,  tsmux_d;
  logic [NUM_IO-1:0]   dor_q,    dor_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;

  logic [7:0]          sync_shift;
  logic [HUNT_W-1:0]   hunt_inc;

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_q;
    hunt_d     = hunt_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    par_d      = par_q;
    tsmux_d    = tsmux_q;
    dor_d      = dor_q;
    done_d     = 1'b0;
    err_d      = err_q;
    sync_shift = {sync_q, cfg.CFG_DIN};
    hunt_inc   = (hunt_q == HUNT_MAX) ? hunt_q : hunt_q + 1'b1;

    case (state_q)
      S_IDLE: ;
      S_SYNC: begin
        if (cfg.CFG_VALID) begin
          sync_d = sync_shift[6:0];
          hunt_d = hunt_inc;
          if (sync_shift == SYNC_WORD) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            par_d   = 1'b0;
          end else if (hunt_inc == HUNT_MAX) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Bits enter at the top and drift down, so payload bit k lands at index k.
        if (cfg.CFG_VALID) begin
          shadow_d = {cfg.CFG_DIN, shadow_q[PW-1:1]};
          par_d    = par_q ^ cfg.CFG_DIN;
          if (cnt_q == LAST_BIT) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (cfg.CFG_VALID) begin
          if ((cfg.CFG_DIN ^ par_q) == 1'b0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        for (int unsigned i = 0; i < NUM_IO; i++) begin
          tsmux_d[2*i+1] = shadow_q[3*i];
          tsmux_d[2*i]   = shadow_q[3*i+1];
          dor_d[i]       = shadow_q[3*i+2];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A start pulse restarts the frame from any state; a commit in flight still lands.
    if (cfg.CFG_START) begin
      state_d  = S_SYNC;
      sync_d   = '0;
      hunt_d   = '0;
      cnt_d    = '0;
      shadow_d = '0;
      par_d    = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      hunt_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      par_q    <= 1'b0;
      tsmux_q  <= '0;
      dor_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hunt_q   <= hunt_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      par_q    <= par_d;
      tsmux_q  <= tsmux_d;
      dor_q    <= dor_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg.TSMUX_OUT  = tsmux_q;
  assign cfg.DORREG_OUT = dor_q;
  assign cfg.BUSY       = (state_q != S_IDLE);
  assign cfg.CFG_DONE   = done_q;
  assign cfg.CFG_ERR    = err_q;

endmodule

// File: tb/tb_io_config_loader.sv
// Directed bench for io_config_loader with NUM_IO=2 and hand-computed expectations.
module tb_io_config_loader;

  logic IOCLK = 1'b0;
  logic RST   = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  always #5 IOCLK = ~IOCLK;

  io_config_loader_if #(.NUM_IO(2)) cfg ();

  io_config_loader #(
    .NUM_IO(2),
    .SYNC_WORD(8'hA5),
    .SYNC_TIMEOUT(64)
  ) dut (
    .IOCLK(IOCLK),
    .RST(RST),
    .cfg(cfg)
  );

  always @(negedge IOCLK) if (cfg.CFG_DONE === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge IOCLK);
    #1;
  endtask

  task automatic start();
    cfg.CFG_START = 1'b1;
    tick();
    cfg.CFG_START = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit stall);
    if (stall) begin
      cfg.CFG_DIN   = ~b;
      cfg.CFG_VALID = 1'b0;
      tick();
    end
    cfg.CFG_DIN   = b;
    cfg.CFG_VALID = 1'b1;
    tick();
    cfg.CFG_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit stall);
    for (int i = 7; i >= 0; i--) send_bit(w[i], stall);
  endtask

  task automatic send_payload(input logic [5:0] p, input bit stall);
    for (int i = 5; i >= 0; i--) send_bit(p[i], stall);
  endtask

  task automatic frame(input logic [5:0] p, input logic par, input bit stall);
    start();
    send_word(8'hA5, stall);
    send_payload(p, stall);
    send_bit(par, stall);
  endtask

  // Called one cycle after the parity bit was sampled.
  task automatic expect_commit(input string tag, input logic [3:0] ts, input logic [1:0] dor);
    int d0;
    d0 = done_cnt;
    check({tag, "_busy_pre"}, cfg.BUSY, 1);
    check({tag, "_done_pre"}, cfg.CFG_DONE, 0);
    tick();
    check({tag, "_tsmux"}, cfg.TSMUX_OUT, ts);
    check({tag, "_dorreg"}, cfg.DORREG_OUT, dor);
    check({tag, "_done"}, cfg.CFG_DONE, 1);
    check({tag, "_busy_post"}, cfg.BUSY, 0);
    check({tag, "_err"}, cfg.CFG_ERR, 0);
    tick();
    check({tag, "_done_drop"}, cfg.CFG_DONE, 0);
    check({tag, "_done_count"}, done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    cfg.CFG_START = 1'b0;
    cfg.CFG_DIN   = 1'b0;
    cfg.CFG_VALID = 1'b0;

    // Asynchronous reset mid-cycle, before any clock edge
    #2 RST = 1'b1;
    #1;
    check("rst_tsmux", cfg.TSMUX_OUT, 0);
    check("rst_dorreg", cfg.DORREG_OUT, 0);
    check("rst_busy", cfg.BUSY, 0);
    check("rst_err", cfg.CFG_ERR, 0);
    check("rst_done", cfg.CFG_DONE, 0);
    tick();
    RST = 1'b0;
    tick();

    // Parity error: payload 011 100 has odd parity, so parity bit 0 is wrong
    d0 = done_cnt;
    frame(6'b011100, 1'b0, 1'b0);
    check("perr_err", cfg.CFG_ERR, 1);
    check("perr_busy", cfg.BUSY, 0);
    tick();
    tick();
    check("perr_tsmux", cfg.TSMUX_OUT, 0);
    check("perr_dorreg", cfg.DORREG_OUT, 0);
    check("perr_no_done", done_cnt, d0);
    check("perr_err_sticky", cfg.CFG_ERR, 1);

    // Good frame
    frame(6'b011100, 1'b1, 1'b0);
    expect_commit("good", 4'b1001, 2'b01);

    // Sync timeout with idle cycles in the middle that must not count
    start();
    check("to_err_cleared", cfg.CFG_ERR, 0);
    for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 31; i++) send_bit(1'b0, 1'b0);
    check("to_busy_63", cfg.BUSY, 1);
    check("to_err_63", cfg.CFG_ERR, 0);
    send_bit(1'b0, 1'b0);
    check("to_err_64", cfg.CFG_ERR, 1);
    check("to_busy_64", cfg.BUSY, 0);
    check("to_tsmux_kept", cfg.TSMUX_OUT, 4'b1001);

    // Sync completing on the 64th hunt bit beats the timeout
    start();
    for (int i = 0; i < 56; i++) send_bit(1'b0, 1'b0);
    send_word(8'hA5, 1'b0);
    check("edge_busy", cfg.BUSY, 1);
    check("edge_err", cfg.CFG_ERR, 0);
    send_payload(6'b000111, 1'b0);
    send_bit(1'b1, 1'b0);
    expect_commit("edge", 4'b1100, 2'b10);

    // Abort after 3 payload bits, then a full frame
    start();
    send_word(8'hA5, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    frame(6'b111000, 1'b1, 1'b0);
    expect_commit("abort", 4'b0011, 2'b01);

    // Stalled good frame with inverted data on the stall cycles
    frame(6'b011100, 1'b1, 1'b1);
    expect_commit("stall", 4'b1001, 2'b01);

    // Reset mid-LOAD wipes the committed configuration
    start();
    send_word(8'hA5, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("mid_busy", cfg.BUSY, 1);
    #3 RST = 1'b1;
    #1;
    check("mid_rst_tsmux", cfg.TSMUX_OUT, 0);
    check("mid_rst_dorreg", cfg.DORREG_OUT, 0);
    check("mid_rst_busy", cfg.BUSY, 0);
    tick();
    RST = 1'b0;
    tick();
    frame(6'b011100, 1'b1, 1'b0);
    expect_commit("after_rst", 4'b1001, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_config_loader.md
Name: io_config_loader

Overview:
- Serial configuration loader directly upstream of the IO block array.
- Receives a framed configuration bitstream, checks it, and commits per-pin TSMUX[1:0] and DORREG settings to NUM_IO IO blocks atomically.
- IO blocks keep their safe state (high-Z, direct input) until a valid frame commits.

Parameters:
- NUM_IO, 8, number of IO blocks configured; each consumes 3 payload bits.
- SYNC_WORD, 8'hA5, frame sync pattern, received MSB first.
- SYNC_TIMEOUT, 64, maximum valid bits accepted while hunting for sync before an error.

Ports:
- IOCLK  input  1  sole clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- CFG_START  input  1  one-cycle pulse that begins a frame load.
- CFG_DIN  input  1  serial config data bit.
- CFG_VALID  input  1  CFG_DIN is sampled only on edges where this is 1.
- TSMUX_OUT  output  2*NUM_IO  committed TSMUX; IO i uses bits [2i+1:2i].
- DORREG_OUT  output  NUM_IO  committed DORREG; IO i uses bit i.
- BUSY  output  1  high in any state other than IDLE.
- CFG_DONE  output  1  one-cycle pulse on commit.
- CFG_ERR  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports IOCLK, RST).
- Reset values:
  - TSMUX_OUT = 0 and DORREG_OUT = 0 (all pins high-Z, direct input).
  - BUSY = 0, CFG_DONE = 0, CFG_ERR = 0.
  - FSM in IDLE; shadow register and counters cleared.
- FSM states: IDLE, SYNC, LOAD, CHECK, COMMIT.
- IDLE:
  - CFG_START=1 -> SYNC; clear CFG_ERR, the 8-bit sync shifter, and the bit counter.
  - CFG_DIN is ignored in IDLE.
- SYNC:
  - Each valid bit shifts into the sync shifter (left shift, new bit in LSB) and increments the hunt counter.
  - The shifter value after the shift equals SYNC_WORD -> LOAD, payload counter = 0.
  - Otherwise, if the hunt counter reaches SYNC_TIMEOUT -> IDLE with CFG_ERR=1.
  - A sync match on the SYNC_TIMEOUT-th bit itself wins over the timeout.
- LOAD:
  - Accepts exactly 3*NUM_IO valid bits into the shadow register.
  - Order: IO0 TSMUX[1], IO0 TSMUX[0], IO0 DORREG, IO1 TSMUX[1], and so on.
  - The running even-parity accumulator XORs in each bit.
  - After the last payload bit -> CHECK.
- CHECK:
  - The next valid bit is the parity bit.
  - Parity bit XOR accumulator == 0 -> COMMIT.
  - Otherwise -> IDLE with CFG_ERR=1; outputs unchanged.
- COMMIT (one cycle):
  - Copy shadow to TSMUX_OUT/DORREG_OUT on the same edge as CFG_DONE goes high.
  - CFG_DONE=1 for exactly this one cycle; next state IDLE.
  - Latency: outputs change on the edge after the edge that sampled the parity bit.
- Stalls: CFG_VALID=0 holds all state and counters in SYNC, LOAD and CHECK. No timeout runs on idle cycles.
- CFG_START while BUSY: abort the current frame, restart at SYNC, clear counters, shadow, parity and CFG_ERR. Outputs keep their last committed values.
- CFG_START in the same cycle as COMMIT: commit completes; next state is SYNC instead of IDLE.
- RST mid-frame: immediate return to reset values. Previously committed configuration is lost and pins return to high-Z.
- CFG_ERR stays high until the next CFG_START or RST.
- Width rules: the payload counter is sized for 3*NUM_IO. The hunt counter is sized for SYNC_TIMEOUT and saturates.

Test Plan:
- Reset: assert RST asynchronously mid-cycle -> TSMUX_OUT=0, DORREG_OUT=0, BUSY=0, CFG_ERR=0 immediately, no clock needed.
- Good frame, NUM_IO=2:
  - Stimulus: START, then bits 10100101, payload 011 100, parity 1.
  - Required: TSMUX_OUT=4'b1001, DORREG_OUT=2'b01, CFG_DONE high exactly one cycle, BUSY low afterwards.
- Parity error: same frame with parity 0 -> CFG_ERR=1, outputs stay at the prior values (0 after reset), no CFG_DONE.
- Sync timeout: START, then 64 valid zeros -> CFG_ERR=1 after the 64th bit, FSM in IDLE, BUSY=0.
- Stall and abort:
  - Good frame with CFG_VALID toggled 0/1 every cycle -> same result as the unstalled frame.
  - Second case: CFG_START pulsed after 3 payload bits, then a full good frame with payload 111 000 and parity 1 -> TSMUX_OUT=4'b0011, DORREG_OUT=2'b01.
- RST mid-LOAD after a prior commit -> outputs forced to 0. A following good frame commits normally.
